radiant_event_hdr_reader: RTL
=============================

// Module: radiant_event_hdr_reader
// PURPOSE
//  Wishbone master that drains event headers from the event control core's header FIFO window.
//  When the core reports a completed event, it reads the NUM_DWORDS header dwords at BASE_ADDR.
//  It forwards them as one framed 32-bit stream packet (last flag on the final dword).
//  It then pops the core's event-type FIFO. Sits between the event control core and the DMA/stream packer.
// PARAMETERS
//  BASE_ADDR    9'h100        byte address of header dword 0; dword n read at BASE_ADDR+4*n
//  NUM_DWORDS   8             header dwords per event (2..8)
//  IDENT        32'h52444530  expected dword 0 ("RDE0")
//  ACK_TIMEOUT  64            cycles to wait for ack before abandoning one read (>=4)
// PORTS
//  clk_i                  in   1   single clock; all logic on rising edge
//  rst_i                  in   1   synchronous, active-high reset
//  enable_i               in   1   allow starting a new event readout
//  event_ready_i          in   1   core type-FIFO valid: a completed event header is available
//  event_ready_type_i     in   1   event type of head event (forwarded, unused in logic)
//  event_readout_ready_o  out  1   1-cycle pulse: header consumed, pop type FIFO
//  wb_cyc_o/wb_stb_o      out  1   Wishbone classic master strobes
//  wb_we_o                out  1   always 0
//  wb_sel_o               out  4   always 4'hF
//  wb_adr_o               out  9   byte address
//  wb_dat_i               in   32  read data
//  wb_ack_i/wb_err_i/wb_rty_i in 1 cycle termination
//  m_tdata                out  32  header dword
//  m_tvalid/m_tready      out/in 1 stream handshake; transfer when both high
//  m_tlast                out  1   high with dword NUM_DWORDS-1
//  m_tuser                out  1   event_ready_type_i latched at event start
//  busy_o                 out  1   state != IDLE
//  hdr_err_o              out  1   sticky: ident mismatch, wb_err, or timeout seen; cleared by reset only
//  event_count_o          out  16  events completed since reset, wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; dword index 0; counters 0.
//  States: IDLE -> REQ -> HOLD -> (REQ | POP) ; POP -> GAP -> IDLE.
//  IDLE: if enable_i && event_ready_i: latch type, idx<=0, go REQ (cyc/stb rise next cycle).
//  REQ: cyc=stb=1, adr=BASE_ADDR+{idx,2'b00}; timer counts up from 0.
//   - ack_i: capture dat_i to m_tdata, drop cyc/stb next cycle, go HOLD.
//   - err_i, rty_i, or timer==ACK_TIMEOUT-1: m_tdata<=32'hFFFFFFFF, set hdr_err_o, drop cyc/stb, go HOLD.
//   - ack and err in the same cycle: err wins.
//  HOLD: m_tvalid=1, m_tlast=(idx==NUM_DWORDS-1); data stable while !m_tready.
//   On transfer: if last -> POP; else idx++ and go REQ. No new bus cycle until prior dword accepted.
//  idx==0 dword compared to IDENT at capture; mismatch sets hdr_err_o, packet still emitted in full.
//  POP: event_readout_ready_o=1 for exactly one cycle; event_count_o++.
//  GAP: one idle cycle so core's FIFO valid reflects the pop before IDLE re-samples.
//  Packets are always exactly NUM_DWORDS dwords; errors only corrupt data, never framing.
//  enable_i low mid-packet: current packet completes; no new packet starts.
//  event_ready_i drop mid-packet: ignored; the pop still issues.
//  Reset mid-operation:
//   - cyc/stb/tvalid low the following cycle; partial packet abandoned without tlast.
//   - no pop; the core's event stays queued.
//  Latency: IDLE->first stb 1 cycle; last ack->tvalid 1 cycle; last transfer->pop 1 cycle.
// TESTING
//  1 Model slave, ack 1 cycle after stb, tready=1, one event:
//    - 8 reads at 0x100..0x11C; 8 beats, tlast on 8th;
//    - single pop pulse; event_count_o=1; hdr_err_o=0.
//  2 tready low for 10 cycles on beat 3:
//    - tdata held; no wb_cyc_o until accepted;
//    - beats delivered in order 0..7.
//  3 Slave never acks dword 4:
//    - stb drops after 64 cycles; beat 4 = 0xFFFFFFFF; hdr_err_o=1;
//    - packet still 8 beats, pop issued.
//  4 Dword 0 returns 0x12345678: hdr_err_o=1; packet and pop unaffected.
//  5 event_ready_i held high for 3 queued events:
//    - 3 packets of 8 beats; 3 pops with >=1 idle (GAP) cycle between packets;
//    - event_count_o=3.
//  6 rst_i asserted during beat 5:
//    - all outputs 0 the next cycle; no pop; event_count_o=0;
//    - after release, full 8-beat re-read of the same event.

Source files
------------

// File: rtl/radiant_event_hdr_reader.sv
// Wishbone reader that drains one event header from the event control core
// and emits it as a single framed 32-bit stream packet, then pops the type FIFO.
module radiant_event_hdr_reader #(
    parameter logic [8:0]  BASE_ADDR   = 9'h100,
    parameter int          NUM_DWORDS  = 8,
    parameter logic [31:0] IDENT       = 32'h52444530,
    parameter int          ACK_TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        event_ready_i,
    input  logic        event_ready_type_i,
    output logic        event_readout_ready_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [8:0]  wb_adr_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        m_tuser,
    output logic        busy_o,
    output logic        hdr_err_o,
    output logic [15:0] event_count_o
);

    localparam int IDX_W = (NUM_DWORDS > 1) ? $clog2(NUM_DWORDS) : 1;
    localparam int TMR_W = $clog2(ACK_TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DWORDS - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        HOLD = 3'd2,
        POP  = 3'd3,
        GAP  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [TMR_W-1:0]  timer_q;
    logic [31:0]       tdata_q;
    logic              tuser_q;
    logic              hdr_err_q;
    logic [15:0]       count_q;
    logic              is_last;
    logic              bus_fault;
    logic              start;

    assign is_last   = (idx_q == LAST_IDX);
    assign start     = enable_i && event_ready_i;
    // Error, retry and timeout all terminate the read with poisoned data; they beat a concurrent ack.
    assign bus_fault = wb_err_i || wb_rty_i || (timer_q == TMR_MAX);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = REQ;
            REQ:     if (bus_fault || wb_ack_i) state_d = HOLD;
            HOLD:    if (m_tready) state_d = is_last ? POP : REQ;
            POP:     state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            timer_q   <= '0;
            tdata_q   <= '0;
            tuser_q   <= 1'b0;
            hdr_err_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_q   <= '0;
                        timer_q <= '0;
                        tuser_q <= event_ready_type_i;
                    end
                end
                REQ: begin
                    if (bus_fault) begin
                        tdata_q   <= 32'hFFFF_FFFF;
                        hdr_err_q <= 1'b1;
                        timer_q   <= '0;
                    end else if (wb_ack_i) begin
                        tdata_q <= wb_dat_i;
                        timer_q <= '0;
                        if (idx_q == '0 && wb_dat_i != IDENT) hdr_err_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                HOLD: begin
                    if (m_tready && !is_last) idx_q <= idx_q + IDX_W'(1);
                end
                POP: count_q <= count_q + 16'd1;
                default: ;
            endcase
        end
    end

    assign wb_cyc_o              = (state_q == REQ);
    assign wb_stb_o              = (state_q == REQ);
    assign wb_we_o               = 1'b0;
    assign wb_sel_o              = 4'hF;
    assign wb_adr_o              = (state_q == REQ) ? BASE_ADDR + 9'({idx_q, 2'b00}) : 9'h000;
    assign m_tdata               = tdata_q;
    assign m_tvalid              = (state_q == HOLD);
    assign m_tlast               = (state_q == HOLD) && is_last;
    assign m_tuser               = tuser_q;
    assign event_readout_ready_o = (state_q == POP);
    assign busy_o                = (state_q != IDLE);
    assign hdr_err_o             = hdr_err_q;
    assign event_count_o         = count_q;

endmodule
